mem_arbiter: RTL

Two-port arbiter and owner of the shared 16 x 8 memory used by the accumulator CPU. Port 0 serves the CPU fetch/execute path and port 1 serves a program loader or debug port. Each access is a single-beat request/grant/acknowledge transaction. The block serialises the two ports onto one memory array, so the CPU and the loader never touch memory in the same cycle.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_pick2.sv | 33 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default geometry,
// FSM state encoding and port index constants.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational winner select for two requesters.
// ARB_RR_EN defined: round-robin on ties; undefined: port 0 fixed priority.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_win,
  output logic win
);

`ifdef ARB_RR_EN
  always_comb begin
    win = PORT_CPU;
    if (req0 && req1) begin
      win = ~last_win;
    end else if (req1) begin
      win = PORT_LDR;
    end
  end
`else
  logic unused_last_win;
  assign unused_last_win = last_win;

  always_comb begin
    win = PORT_CPU;
    if (!req0 && req1) begin
      win = PORT_LDR;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port request/grant/ack arbiter owning a single-port memory array.
// Arbitration policy selected by ARB_RR_EN (round-robin) vs fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t state_q, state_d;

  logic              win;
  logic              win_q;
  logic              last_win;
  logic              grant_go;
  logic              exec;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  arb_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_win (last_win),
    .win      (win)
  );

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win <= PORT_LDR;
    end else if (grant_go) begin
      last_win <= win;
    end
  end
`else
  assign last_win = PORT_LDR;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0 || req1) state_d = GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_go = 1'b0;
    exec     = 1'b0;
    unique case (state_q)
      IDLE:    grant_go = req0 || req1;
      GRANT:   exec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      win_q   <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      gnt0 <= grant_go && (win == PORT_CPU);
      gnt1 <= grant_go && (win == PORT_LDR);
      ack0 <= exec && (win_q == PORT_CPU);
      ack1 <= exec && (win_q == PORT_LDR);
      // Capture the winner's command so the requester is free after gnt.
      if (grant_go) begin
        win_q   <= win;
        we_q    <= (win == PORT_LDR) ? we1    : we0;
        addr_q  <= (win == PORT_LDR) ? addr1  : addr0;
        wdata_q <= (win == PORT_LDR) ? wdata1 : wdata0;
      end
      if (exec && !we_q) begin
        if (win_q == PORT_LDR) begin
          rdata1 <= mem[addr_q];
        end else begin
          rdata0 <= mem[addr_q];
        end
      end
    end
  end

  // No reset on the array; exec is cleared by reset, so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (exec && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule
